// File: rtl/boot_loader.sv
// boot_loader: receives a length/payload/XOR-checksum byte frame, writes the payload to memory,
// and keeps the processor in reset until a frame with a good checksum has been accepted.
module boot_loader #(
  parameter int DEPTH = 32,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       reload,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] error_code
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] DMAX = 8'(DEPTH);
  typedef enum logic [2:0] {IDLE, DATA, WRITE, CSUM, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, len, len_n, csum, csum_n, addr_n, data_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [1:0] code_n;
  logic xfer;
  assign in_ready = (state == IDLE || state == DATA || state == CSUM) && !reload && rst;
  assign xfer = in_valid && in_ready;
  assign mem_wr = state == WRITE;
  assign mem_rd = 1'b0;
  assign cpu_hold = state != DONE;
  assign busy = state == DATA || state == WRITE || state == CSUM;
  assign done = state == DONE;
  assign error = state == ERROR;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    len_n = len;
    csum_n = csum;
    tmo_n = tmo;
    addr_n = mem_addr;
    data_n = mem_data;
    code_n = error_code;
    if (reload) begin
      state_n = IDLE;
      code_n = 2'b00;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          if (in_data == 8'd0 || in_data > DMAX) begin
            state_n = ERROR;
            code_n = 2'b01;
          end else begin
            len_n = in_data;
            cnt_n = 8'd0;
            csum_n = 8'd0;
            tmo_n = '0;
            state_n = DATA;
          end
        end
        DATA: if (xfer) begin
          data_n = in_data;
          addr_n = BASE_ADDR + cnt;
          csum_n = csum ^ in_data;
          tmo_n = '0;
          state_n = WRITE;
        end else if (tmo == TLAST) begin
          state_n = ERROR;
          code_n = 2'b11;
        end else tmo_n = tmo + 1'b1;
        WRITE: begin
          cnt_n = cnt + 8'd1;
          tmo_n = '0;
          state_n = (cnt + 8'd1 == len) ? CSUM : DATA;
        end
        CSUM: if (xfer) begin
          state_n = (in_data == csum) ? DONE : ERROR;
          code_n = (in_data == csum) ? error_code : 2'b10;
        end else if (tmo == TLAST) begin
          state_n = ERROR;
          code_n = 2'b11;
        end else tmo_n = tmo + 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      len <= 8'd0;
      csum <= 8'd0;
      tmo <= '0;
      mem_addr <= 8'd0;
      mem_data <= 8'd0;
      error_code <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      len <= len_n;
      csum <= csum_n;
      tmo <= tmo_n;
      mem_addr <= addr_n;
      mem_data <= data_n;
      error_code <= code_n;
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed and random frames checked against a frame-level reference model.
module tb_boot_loader;
  localparam int DEPTH = 32;
  localparam logic [7:0] BASE = 8'h00;
  localparam int TMO = 16;
  logic clk = 0, rst = 0, in_valid = 0, reload = 0;
  logic [7:0] in_data = 0;
  logic in_ready, mem_wr, mem_rd, cpu_hold, busy, done, error;
  logic [7:0] mem_addr, mem_data;
  logic [1:0] error_code;
  int total = 0, bad = 0;
  logic [15:0] writes[$];
  logic [7:0] pl[64];
  boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .error_code(error_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (mem_wr) begin
    writes.push_back({mem_addr, mem_data});
    check("ready_in_write", in_ready, 0);
    check("mem_rd", mem_rd, 0);
  end
  task automatic push(input logic [7:0] b, input int gap);
    bit ok = 0;
    in_valid = 0;
    repeat (gap) @(negedge clk);
    in_data = b;
    in_valid = 1;
    for (int k = 0; k < 64 && !ok; k++) begin
      #1;
      if (in_ready) ok = 1;
      @(negedge clk);
    end
    in_valid = 0;
    if (!ok) check("push_stall", 0, 1);
  endtask
  task automatic do_reload();
    @(negedge clk);
    reload = 1;
    #1 check("ready_reload", in_ready, 0);
    @(negedge clk);
    reload = 0;
    #1;
    check("rl_busy", busy, 0);
    check("rl_done", done, 0);
    check("rl_error", error, 0);
    check("rl_code", error_code, 0);
    check("rl_hold", cpu_hold, 1);
    check("rl_ready", in_ready, 1);
  endtask
  task automatic run_frame(input int l, input logic [7:0] cs, input int maxgap);
    logic [7:0] x = 0;
    bit len_ok = l >= 1 && l <= DEPTH;
    writes.delete();
    push(8'(l), 0);
    if (!len_ok) begin
      check("bl_error", error, 1);
      check("bl_code", error_code, 2'b01);
      check("bl_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      check("bl_nowrite", writes.size(), 0);
      return;
    end
    check("busy", busy, 1);
    for (int i = 0; i < l; i++) begin
      push(pl[i], $urandom_range(maxgap));
      x ^= pl[i];
    end
    push(cs, $urandom_range(maxgap));
    check("nwrites", writes.size(), l);
    for (int i = 0; i < l && i < writes.size(); i++) check("write", writes[i], {BASE + 8'(i), pl[i]});
    check("done", done, cs == x);
    check("error", error, cs != x);
    check("code", error_code, (cs == x) ? 2'b00 : 2'b10);
    check("hold", cpu_hold, cs != x);
    check("ready_end", in_ready, 0);
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_flags", {busy, done, error, error_code}, 0);
    rst = 1;
    pl[0] = 8'hA0; pl[1] = 8'h21; pl[2] = 8'hE2;
    run_frame(3, 8'h63, 0);
    do_reload();
    pl[0] = 8'h11; pl[1] = 8'h22;
    run_frame(2, 8'h00, 0);
    do_reload();
    run_frame(0, 8'h00, 0);
    do_reload();
    run_frame(8'h21, 8'h00, 0);
    do_reload();
    writes.delete();
    push(8'h04, 0);
    push(8'h55, 0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (error) k = i;
    end
    check("tmo_cycles", k, 17);
    check("tmo_code", error_code, 2'b11);
    check("tmo_writes", writes.size(), 1);
    do_reload();
    push(8'h04, 0);
    push(8'h55, 0);
    repeat (16) @(negedge clk);
    in_data = 8'h66;
    in_valid = 1;
    #1 check("tmo_edge_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    check("tmo_edge_err", error, 0);
    check("tmo_edge_wr", mem_wr, 1);
    check("tmo_edge_data", mem_data, 8'h66);
    do_reload();
    for (int i = 0; i < 32; i++) pl[i] = 8'(i);
    run_frame(32, 8'h00, 0);
    check("full_last", writes.size() > 0 ? writes[writes.size()-1] : 16'hFFFF, 16'h1F1F);
    do_reload();
    writes.delete();
    for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
    push(8'd10, 0);
    for (int i = 0; i < 5; i++) push(pl[i], 0);
    check("mr_inwrite", mem_wr, 1);
    rst = 0;
    in_valid = 1;
    @(negedge clk);
    check("mr_flags", {in_ready, mem_wr, cpu_hold, busy, done, error}, 6'b001000);
    check("mr_regs", {mem_addr, mem_data, error_code}, 0);
    repeat (4) @(negedge clk);
    check("mr_writes", writes.size(), 5);
    in_valid = 0;
    rst = 1;
    for (int i = 0; i < 6; i++) pl[i] = 8'($urandom);
    run_frame(6, pl[0] ^ pl[1] ^ pl[2] ^ pl[3] ^ pl[4] ^ pl[5], 1);
    do_reload();
    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(7);
      int l = kind == 0 ? 0 : kind == 1 ? $urandom_range(255, 33) : $urandom_range(32, 1);
      logic [7:0] cs = 0;
      for (int i = 0; i < 32; i++) pl[i] = 8'($urandom);
      for (int i = 0; i < l && i < 32; i++) cs ^= pl[i];
      if ($urandom_range(3) == 0) cs ^= 8'($urandom_range(255, 1));
      run_frame(l, cs, $urandom_range(3));
      do_reload();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
